// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: decoded instruction, forwarding sources, pipeline control
// and the registered ALU-facing outputs of the ID/EX stage.
interface id_ex_if;
  logic        valid_in;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        stall;
  logic        flush;
  logic        hazard_stall;
  logic        valid_out;
  logic        reg_write_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic        branch_out;
  logic        illegal_out;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] store_data;
  logic [4:0]  rd_out;

  modport slave (
    input  valid_in, opcode, funct3, funct7b5, rs1_addr, rs2_addr, rd_addr,
    input  rs1_data, rs2_data, imm,
    input  exmem_reg_write, exmem_rd, exmem_result,
    input  memwb_reg_write, memwb_rd, memwb_result,
    input  stall, flush,
    output hazard_stall, valid_out, reg_write_out, mem_read_out, mem_write_out,
    output branch_out, illegal_out, alu_op, alu_a, alu_b, store_data, rd_out
  );

  modport master (
    output valid_in, opcode, funct3, funct7b5, rs1_addr, rs2_addr, rd_addr,
    output rs1_data, rs2_data, imm,
    output exmem_reg_write, exmem_rd, exmem_result,
    output memwb_reg_write, memwb_rd, memwb_result,
    output stall, flush,
    input  hazard_stall, valid_out, reg_write_out, mem_read_out, mem_write_out,
    input  branch_out, illegal_out, alu_op, alu_a, alu_b, store_data, rd_out
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: ALU opcode decode, EX/MEM and MEM/WB operand forwarding,
// load-use hazard detection, and the registered operands/control feeding the ALU.
module id_ex_stage (
  input logic     clk,
  input logic     reset,
  id_ex_if.slave  bus
);
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluXor = 4'b0011;
  localparam logic [3:0] AluSub = 4'b0110;

  logic        uses_rs1, uses_rs2, use_imm, f3_ok;
  logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_illegal;
  logic [3:0]  f3_op, dec_alu_op;
  logic [31:0] fwd_a, fwd_b;

  logic        valid_q, reg_write_q, mem_read_q, mem_write_q, branch_q, illegal_q;
  logic [3:0]  alu_op_q;
  logic [31:0] alu_a_q, alu_b_q, store_data_q;
  logic [4:0]  rd_q;

  always_comb begin
    f3_ok = 1'b1;
    f3_op = AluAdd;
    unique case (bus.funct3)
      3'b000:  f3_op = AluAdd;
      3'b111:  f3_op = AluAnd;
      3'b110:  f3_op = AluOr;
      3'b100:  f3_op = AluXor;
      default: f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    uses_rs1      = 1'b0;
    uses_rs2      = 1'b0;
    use_imm       = 1'b0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    dec_illegal   = 1'b0;
    dec_alu_op    = AluAdd;
    case (bus.opcode)
      OpR: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        if (!f3_ok) begin
          dec_illegal = 1'b1;
        end else begin
          dec_reg_write = 1'b1;
          dec_alu_op    = (bus.funct3 == 3'b000 && bus.funct7b5) ? AluSub : f3_op;
        end
      end
      OpI: begin
        uses_rs1 = 1'b1;
        use_imm  = 1'b1;
        if (!f3_ok) begin
          dec_illegal = 1'b1;
        end else begin
          dec_reg_write = 1'b1;
          dec_alu_op    = f3_op;
        end
      end
      OpLoad: begin
        uses_rs1      = 1'b1;
        use_imm       = 1'b1;
        dec_mem_read  = 1'b1;
        dec_reg_write = 1'b1;
      end
      OpStore: begin
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        use_imm       = 1'b1;
        dec_mem_write = 1'b1;
      end
      OpBranch: begin
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        dec_branch = 1'b1;
        dec_alu_op = AluSub;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // EX/MEM is the younger producer, so it takes precedence over MEM/WB; x0 never forwards.
  always_comb begin
    fwd_a = bus.rs1_data;
    if (bus.rs1_addr != 5'd0 && bus.exmem_reg_write && bus.exmem_rd == bus.rs1_addr) begin
      fwd_a = bus.exmem_result;
    end else if (bus.rs1_addr != 5'd0 && bus.memwb_reg_write &&
                 bus.memwb_rd == bus.rs1_addr) begin
      fwd_a = bus.memwb_result;
    end
    fwd_b = bus.rs2_data;
    if (bus.rs2_addr != 5'd0 && bus.exmem_reg_write && bus.exmem_rd == bus.rs2_addr) begin
      fwd_b = bus.exmem_result;
    end else if (bus.rs2_addr != 5'd0 && bus.memwb_reg_write &&
                 bus.memwb_rd == bus.rs2_addr) begin
      fwd_b = bus.memwb_result;
    end
  end

  assign bus.hazard_stall = bus.valid_in & valid_q & mem_read_q & (rd_q != 5'd0) &
                            ((uses_rs1 & (rd_q == bus.rs1_addr)) |
                             (uses_rs2 & (rd_q == bus.rs2_addr)));

  // Bubble on reset/flush; stall holds; otherwise a hazard or empty slot bubbles.
  always_ff @(posedge clk) begin
    if (reset || bus.flush || (!bus.stall && (bus.hazard_stall || !bus.valid_in))) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      branch_q     <= 1'b0;
      illegal_q    <= 1'b0;
      alu_op_q     <= 4'b0000;
      alu_a_q      <= 32'd0;
      alu_b_q      <= 32'd0;
      store_data_q <= 32'd0;
      rd_q         <= 5'd0;
    end else if (!bus.stall) begin
      valid_q      <= 1'b1;
      reg_write_q  <= dec_reg_write;
      mem_read_q   <= dec_mem_read;
      mem_write_q  <= dec_mem_write;
      branch_q     <= dec_branch;
      illegal_q    <= dec_illegal;
      alu_op_q     <= dec_alu_op;
      alu_a_q      <= fwd_a;
      alu_b_q      <= use_imm ? bus.imm : fwd_b;
      store_data_q <= fwd_b;
      rd_q         <= bus.rd_addr;
    end
  end

  assign bus.valid_out     = valid_q;
  assign bus.reg_write_out = reg_write_q;
  assign bus.mem_read_out  = mem_read_q;
  assign bus.mem_write_out = mem_write_q;
  assign bus.branch_out    = branch_q;
  assign bus.illegal_out   = illegal_q;
  assign bus.alu_op        = alu_op_q;
  assign bus.alu_a         = alu_a_q;
  assign bus.alu_b         = alu_b_q;
  assign bus.store_data    = store_data_q;
  assign bus.rd_out        = rd_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by random traffic, all checked
// against an instruction-level reference model of the stage.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid, rw, mr, mw, br, ill;
    logic [3:0]  op;
    logic [31:0] a, b, sd;
    logic [4:0]  rd;
    bit          chk_b, chk_sd;
  } st_t;

  st_t m;
  bit  known = 0;
  logic [6:0] ops [5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic st_t bubble();
    st_t d;
    d = '{valid: 0, rw: 0, mr: 0, mw: 0, br: 0, ill: 0, op: 4'd0, a: 32'd0, b: 32'd0,
          sd: 32'd0, rd: 5'd0, chk_b: 1, chk_sd: 1};
    return d;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return rf;
    if (bus.exmem_reg_write && bus.exmem_rd == rs) return bus.exmem_result;
    if (bus.memwb_reg_write && bus.memwb_rd == rs) return bus.memwb_result;
    return rf;
  endfunction

  function automatic bit is_r();  return bus.opcode == 7'b0110011; endfunction
  function automatic bit is_i();  return bus.opcode == 7'b0010011; endfunction
  function automatic bit is_l();  return bus.opcode == 7'b0000011; endfunction
  function automatic bit is_s();  return bus.opcode == 7'b0100011; endfunction
  function automatic bit is_b();  return bus.opcode == 7'b1100011; endfunction
  function automatic bit known_op(); return is_r() | is_i() | is_l() | is_s() | is_b(); endfunction

  function automatic logic model_hz();
    bit hit1, hit2;
    hit1 = known_op() && m.rd == bus.rs1_addr;
    hit2 = (is_r() | is_s() | is_b()) && m.rd == bus.rs2_addr;
    return bus.valid_in && m.valid && m.mr && m.rd != 5'd0 && (hit1 || hit2);
  endfunction

  function automatic st_t decode_model();
    st_t d;
    bit  legal_f3;
    d = bubble();
    legal_f3 = bus.funct3 inside {3'b000, 3'b111, 3'b110, 3'b100};
    d.valid = 1;
    d.rd    = bus.rd_addr;
    d.a     = fwd(bus.rs1_addr, bus.rs1_data);
    if (!known_op() || ((is_r() || is_i()) && !legal_f3)) begin
      d.ill = 1; d.op = 4'b0010; d.chk_b = 0; d.chk_sd = 0;
      return d;
    end
    if (is_r() || is_i()) begin
      case (bus.funct3)
        3'b000:  d.op = (is_r() && bus.funct7b5) ? 4'b0110 : 4'b0010;
        3'b111:  d.op = 4'b0000;
        3'b110:  d.op = 4'b0001;
        3'b100:  d.op = 4'b0011;
        default: d.op = 4'b0010;
      endcase
    end else begin
      d.op = is_b() ? 4'b0110 : 4'b0010;
    end
    d.rw     = is_r() | is_i() | is_l();
    d.mr     = is_l();
    d.mw     = is_s();
    d.br     = is_b();
    d.b      = (is_r() || is_b()) ? fwd(bus.rs2_addr, bus.rs2_data) : bus.imm;
    d.sd     = fwd(bus.rs2_addr, bus.rs2_data);
    d.chk_sd = is_s();
    return d;
  endfunction

  task automatic compare_all();
    check("valid_out", 32'(bus.valid_out), 32'(m.valid));
    check("reg_write_out", 32'(bus.reg_write_out), 32'(m.rw));
    check("mem_read_out", 32'(bus.mem_read_out), 32'(m.mr));
    check("mem_write_out", 32'(bus.mem_write_out), 32'(m.mw));
    check("branch_out", 32'(bus.branch_out), 32'(m.br));
    check("illegal_out", 32'(bus.illegal_out), 32'(m.ill));
    check("alu_op", 32'(bus.alu_op), 32'(m.op));
    check("alu_a", bus.alu_a, m.a);
    check("rd_out", 32'(bus.rd_out), 32'(m.rd));
    if (m.chk_b) check("alu_b", bus.alu_b, m.b);
    if (m.chk_sd) check("store_data", bus.store_data, m.sd);
  endtask

  // Inputs are set after a falling edge; this checks hazard_stall, advances one clock
  // and compares every registered output with the model.
  task automatic tick();
    logic hz;
    st_t  nxt;
    #1;
    hz = known ? model_hz() : 1'b0;
    if (known) check("hazard_stall", 32'(bus.hazard_stall), 32'(hz));
    if (reset || bus.flush)            nxt = bubble();
    else if (bus.stall)                nxt = m;
    else if (hz || !bus.valid_in)      nxt = bubble();
    else                               nxt = decode_model();
    @(posedge clk);
    #1;
    m     = nxt;
    known = 1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] im);
    bus.opcode = op; bus.funct3 = f3; bus.funct7b5 = f7;
    bus.rs1_addr = rs1; bus.rs2_addr = rs2; bus.rd_addr = rd;
    bus.rs1_data = d1; bus.rs2_data = d2; bus.imm = im;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    bus.exmem_reg_write = ew; bus.exmem_rd = erd; bus.exmem_result = eres;
    bus.memwb_reg_write = mw; bus.memwb_rd = mrd; bus.memwb_result = mres;
  endtask

  task automatic rand_inputs();
    logic [6:0] op;
    op = ($urandom_range(0, 5) == 5) ? 7'($urandom) : ops[$urandom_range(0, 4)];
    set_instr(op, 3'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
              $urandom);
    set_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom), 5'($urandom_range(0, 7)), $urandom);
  endtask

  initial begin
    // Reset with arbitrary inputs.
    reset = 1'b1;
    rand_inputs();
    bus.valid_in = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
    tick();
    tick();
    check("reset_hazard", 32'(bus.hazard_stall), 32'd0);
    reset = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0);

    // Decode sweep.
    set_instr(7'b0110011, 3'b000, 1'b1, 5, 6, 9, 32'h0000_0055, 32'h0000_0066, 32'h777);
    tick();
    check("r_sub_op", 32'(bus.alu_op), 32'b0110);
    check("r_sub_b", bus.alu_b, 32'h0000_0066);
    set_instr(7'b0010011, 3'b100, 1'b0, 2, 3, 4, 32'h1, 32'h2, 32'hFFFF_FF80);
    tick();
    check("i_xor_op", 32'(bus.alu_op), 32'b0011);
    check("i_xor_b", bus.alu_b, 32'hFFFF_FF80);
    set_instr(7'b0110011, 3'b001, 1'b0, 2, 3, 4, 32'h1, 32'h2, 32'h3);
    tick();
    check("illegal_flag", 32'(bus.illegal_out), 32'd1);
    check("illegal_op", 32'(bus.alu_op), 32'b0010);
    check("illegal_rw", 32'(bus.reg_write_out), 32'd0);

    // Forwarding priority.
    set_instr(7'b0110011, 3'b000, 1'b0, 3, 1, 10, 32'h1111_1111, 32'h2, 32'h0);
    set_fwd(1, 3, 32'hAAAA_0001, 1, 3, 32'hBBBB_0002);
    tick();
    check("fwd_exmem", bus.alu_a, 32'hAAAA_0001);
    bus.exmem_reg_write = 1'b0;
    tick();
    check("fwd_memwb", bus.alu_a, 32'hBBBB_0002);
    set_instr(7'b0110011, 3'b000, 1'b0, 0, 1, 10, 32'h1357_9BDF, 32'h2, 32'h0);
    set_fwd(1, 0, 32'hAAAA_0001, 1, 0, 32'hBBBB_0002);
    tick();
    check("fwd_x0", bus.alu_a, 32'h1357_9BDF);

    // Load-use: lw x7 then add x8,x7,x1.
    set_fwd(0, 0, 0, 0, 0, 0);
    set_instr(7'b0000011, 3'b010, 1'b0, 2, 0, 7, 32'h100, 32'h0, 32'h8);
    tick();
    set_instr(7'b0110011, 3'b000, 1'b0, 7, 1, 8, 32'hDEAD_0000, 32'h5, 32'h0);
    #1;
    check("loaduse_hz", 32'(bus.hazard_stall), 32'd1);
    tick();
    check("loaduse_bubble", 32'(bus.valid_out), 32'd0);
    set_fwd(0, 0, 0, 1, 7, 32'h1234_5678);
    #1;
    check("loaduse_hz_clear", 32'(bus.hazard_stall), 32'd0);
    tick();
    check("loaduse_issue_v", 32'(bus.valid_out), 32'd1);
    check("loaduse_issue_a", bus.alu_a, 32'h1234_5678);

    // Stall holds, then stall+flush bubbles.
    set_fwd(0, 0, 0, 0, 0, 0);
    set_instr(7'b0010011, 3'b000, 1'b0, 4, 0, 11, 32'h0BAD_CAFE, 32'h0, 32'h10);
    tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      tick();
      check("stall_hold_a", bus.alu_a, 32'h0BAD_CAFE);
      check("stall_hold_rd", 32'(bus.rd_out), 32'd11);
    end
    bus.flush = 1'b1;
    tick();
    check("flush_over_stall", 32'(bus.valid_out), 32'd0);
    bus.stall = 1'b0; bus.flush = 1'b0;

    // Store with EX/MEM forwarding of rs2.
    set_instr(7'b0100011, 3'b010, 1'b0, 2, 4, 0, 32'h200, 32'h4444, 32'h0000_0024);
    set_fwd(1, 4, 32'hCAFE_F00D, 0, 0, 0);
    tick();
    check("sw_data", bus.store_data, 32'hCAFE_F00D);
    check("sw_b", bus.alu_b, 32'h0000_0024);
    check("sw_mw", 32'(bus.mem_write_out), 32'd1);
    check("sw_rw", 32'(bus.reg_write_out), 32'd0);

    // Mid-stream reset.
    set_fwd(0, 0, 0, 0, 0, 0);
    set_instr(7'b0110011, 3'b111, 1'b0, 1, 2, 3, 32'hF0, 32'h0F, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    check("midreset_valid", 32'(bus.valid_out), 32'd0);
    reset = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      bus.valid_in = ($urandom_range(0, 4) != 0);
      bus.stall    = ($urandom_range(0, 7) == 0);
      bus.flush    = ($urandom_range(0, 11) == 0);
      reset        = ($urandom_range(0, 59) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
